host_bus_master: RTL and testbench



---
 rtl/host_bus_master_pkg.sv | 19 +
 rtl/host_bus_master.sv | 145 ++++++++++++++
 tb/tb_host_bus_master.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_bus_master_pkg.sv
// Shared definitions for the PET memory bus host initiator.
// Holds the initiator state encoding, the bus address/data widths and the
// default strobe length. The address decoder and the CPU/host arbiter use
// the same address width.
package host_bus_master_pkg;

    localparam int PET_ADDR_WIDTH    = 17;
    localparam int PET_DATA_WIDTH    = 8;
    localparam int PET_ACCESS_CYCLES = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SLOT = 3'd1,
        ST_SETUP     = 3'd2,
        ST_STROBE    = 3'd3,
        ST_HOLD      = 3'd4
    } hbm_state_e;

endpackage

// File: rtl/host_bus_master.sv
// host_bus_master: host-side initiator for the PET memory bus.
// Accepts one read/write command at a time from the host bridge, waits for
// a bus slot from the arbiter, then runs a fixed-length RAM access:
// one clock of address setup, ACCESS_CYCLES clocks of strobe, one clock of
// hold. Writes are not filtered by any read-only attribute, which is how
// ROM images get loaded.
//
// Ports:
//   clk, reset               - single clock, synchronous active-high reset
//   cmd_valid/cmd_ready      - host command handshake
//   cmd_we/addr/wdata        - command contents (1 = write)
//   rsp_valid                - one-clock completion pulse
//   rsp_rdata                - last read data, unchanged by writes
//   slot_grant               - arbiter allows an access to start
//   bus_active               - host owns the bus (SETUP..HOLD)
//   bus_addr                 - address to the bus and decoder
//   bus_wdata, bus_wdata_oe  - write data and its drive enable
//   bus_rdata                - data bus readback
//   ram_oe, ram_we           - registered RAM strobes, active-high
module host_bus_master
    import host_bus_master_pkg::*;
#(
    parameter int ADDR_WIDTH    = PET_ADDR_WIDTH,
    parameter int DATA_WIDTH    = PET_DATA_WIDTH,
    parameter int ACCESS_CYCLES = PET_ACCESS_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  slot_grant,
    output logic                  bus_active,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic                  bus_wdata_oe,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  ram_oe,
    output logic                  ram_we
);

    // One extra bit so ACCESS_CYCLES-1 always fits without wrapping.
    localparam int CNT_WIDTH = $clog2(ACCESS_CYCLES) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(ACCESS_CYCLES - 1);

    hbm_state_e            state_reg;
    logic                  we_reg;
    logic [CNT_WIDTH-1:0]  cnt_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  rsp_valid_reg;
    logic                  bus_active_reg;
    logic                  wdata_oe_reg;
    logic                  ram_oe_reg;
    logic                  ram_we_reg;

    // Ready is gated by reset directly so the host sees it low for the whole
    // reset interval, including the first clock before the state settles.
    assign cmd_ready    = (state_reg == ST_IDLE) && !reset;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_rdata    = rdata_reg;
    assign bus_active   = bus_active_reg;
    assign bus_addr     = addr_reg;
    assign bus_wdata    = wdata_reg;
    assign bus_wdata_oe = wdata_oe_reg;
    assign ram_oe       = ram_oe_reg;
    assign ram_we       = ram_we_reg;

    // All outputs are set on the edge entering the state they belong to, so
    // every strobe comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            we_reg         <= 1'b0;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            rsp_valid_reg  <= 1'b0;
            bus_active_reg <= 1'b0;
            wdata_oe_reg   <= 1'b0;
            ram_oe_reg     <= 1'b0;
            ram_we_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        we_reg    <= cmd_we;
                        addr_reg  <= cmd_addr;
                        wdata_reg <= cmd_wdata;
                        state_reg <= ST_WAIT_SLOT;
                    end
                end
                ST_WAIT_SLOT: begin
                    if (slot_grant) begin
                        bus_active_reg <= 1'b1;
                        state_reg      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cnt_reg      <= CNT_LOAD;
                    ram_oe_reg   <= !we_reg;
                    ram_we_reg   <= we_reg;
                    wdata_oe_reg <= we_reg;
                    state_reg    <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (cnt_reg == '0) begin
                        // Strobes drop entering HOLD; data output enable
                        // stays on for write hold time.
                        ram_oe_reg    <= 1'b0;
                        ram_we_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        if (!we_reg) begin
                            rdata_reg <= bus_rdata;
                        end
                        state_reg <= ST_HOLD;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_WIDTH'(1);
                    end
                end
                ST_HOLD: begin
                    rsp_valid_reg  <= 1'b0;
                    bus_active_reg <= 1'b0;
                    wdata_oe_reg   <= 1'b0;
                    state_reg      <= ST_IDLE;
                end
                default: begin
                    rsp_valid_reg  <= 1'b0;
                    bus_active_reg <= 1'b0;
                    wdata_oe_reg   <= 1'b0;
                    ram_oe_reg     <= 1'b0;
                    ram_we_reg     <= 1'b0;
                    state_reg      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_bus_master.sv
// Testbench for host_bus_master: instance 0 uses the default strobe length
// (3), instance 1 uses a single-clock strobe. Stimulus pushes expected
// responses into per-instance queues; a negedge monitor measures each access
// and compares when rsp_valid appears.
module tb_host_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cmd_valid    [2];
    logic        cmd_ready    [2];
    logic        cmd_we       [2];
    logic [16:0] cmd_addr     [2];
    logic [7:0]  cmd_wdata    [2];
    logic        rsp_valid    [2];
    logic [7:0]  rsp_rdata    [2];
    logic        slot_grant   [2];
    logic        bus_active   [2];
    logic [16:0] bus_addr     [2];
    logic [7:0]  bus_wdata    [2];
    logic        bus_wdata_oe [2];
    logic [7:0]  bus_rdata    [2];
    logic        ram_oe       [2];
    logic        ram_we       [2];

    host_bus_master #(.ADDR_WIDTH(17), .DATA_WIDTH(8), .ACCESS_CYCLES(3)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_we(cmd_we[0]),
        .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .slot_grant(slot_grant[0]), .bus_active(bus_active[0]),
        .bus_addr(bus_addr[0]), .bus_wdata(bus_wdata[0]),
        .bus_wdata_oe(bus_wdata_oe[0]), .bus_rdata(bus_rdata[0]),
        .ram_oe(ram_oe[0]), .ram_we(ram_we[0])
    );

    host_bus_master #(.ADDR_WIDTH(17), .DATA_WIDTH(8), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_we(cmd_we[1]),
        .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .slot_grant(slot_grant[1]), .bus_active(bus_active[1]),
        .bus_addr(bus_addr[1]), .bus_wdata(bus_wdata[1]),
        .bus_wdata_oe(bus_wdata_oe[1]), .bus_rdata(bus_rdata[1]),
        .ram_oe(ram_oe[1]), .ram_we(ram_we[1])
    );

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          latency;  // accept edge to rsp_valid cycle
        int          gap;      // accept cycle minus previous rsp cycle, -1 = skip
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit done_req = 1'b0;
    bit done_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    bit          busy        [2];
    int          base        [2];
    logic [16:0] trk_addr    [2];
    int          oe_n        [2];
    int          we_n        [2];
    int          woe_n       [2];
    int          act_n       [2];
    int          strobe_last [2];
    bit          addr_bad    [2];
    bit          stray       [2];
    bit          prev_rsp    [2];
    int          last_rsp    [2];
    bit          prev_reset = 1'b0;

    initial begin
        for (int d = 0; d < 2; d++) begin
            busy[d] = 0; base[d] = 0; trk_addr[d] = '0; oe_n[d] = 0; we_n[d] = 0;
            woe_n[d] = 0; act_n[d] = 0; strobe_last[d] = 0; addr_bad[d] = 0;
            stray[d] = 0; prev_rsp[d] = 0; last_rsp[d] = 0;
        end
    end

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)",
                     name, d, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int   ac;
            exp_t e;
            ac = (d == 0) ? 3 : 1;
            if (prev_reset) begin
                chk("rst_ram_oe",     d, ram_oe[d],       0);
                chk("rst_ram_we",     d, ram_we[d],       0);
                chk("rst_bus_active", d, bus_active[d],   0);
                chk("rst_wdata_oe",   d, bus_wdata_oe[d], 0);
                chk("rst_rsp_valid",  d, rsp_valid[d],    0);
                chk("rst_rsp_rdata",  d, rsp_rdata[d],    0);
                chk("rst_bus_addr",   d, bus_addr[d],     0);
                chk("rst_bus_wdata",  d, bus_wdata[d],    0);
                chk("rst_cmd_ready",  d, cmd_ready[d],    !reset);
                busy[d]     = 0;
                prev_rsp[d] = 0;
            end else begin
                if (prev_rsp[d]) begin
                    chk("rsp_width",  d, rsp_valid[d], 0);
                    chk("idle_ready", d, cmd_ready[d], 1);
                end
                if (busy[d]) begin
                    if (ram_oe[d] === 1'b1) oe_n[d]++;
                    if (ram_we[d] === 1'b1) we_n[d]++;
                    if (bus_wdata_oe[d] === 1'b1) woe_n[d]++;
                    if (bus_active[d] === 1'b1) act_n[d]++;
                    if (ram_oe[d] === 1'b1 || ram_we[d] === 1'b1) strobe_last[d] = cyc;
                    if (bus_addr[d] !== trk_addr[d]) addr_bad[d] = 1;
                end else if (ram_oe[d] === 1'b1 || ram_we[d] === 1'b1 ||
                             bus_active[d] === 1'b1 || bus_wdata_oe[d] === 1'b1) begin
                    stray[d] = 1;
                end
                prev_rsp[d] = (rsp_valid[d] === 1'b1);
                if (rsp_valid[d] === 1'b1) begin
                    if (!busy[d] || (d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 expected none (cycle %0d)",
                                 d, cyc);
                    end else begin
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk("latency",         d, cyc - base[d],             e.latency);
                        chk("rsp_rdata",       d, rsp_rdata[d],              e.rdata);
                        chk("bus_addr",        d, bus_addr[d],               e.addr);
                        chk("addr_stable",     d, addr_bad[d],               0);
                        chk("ram_oe_clks",     d, oe_n[d],                   e.we ? 0 : ac);
                        chk("ram_we_clks",     d, we_n[d],                   e.we ? ac : 0);
                        chk("strobe_end",      d, strobe_last[d] - base[d],  e.latency - 1);
                        chk("wdata_oe_clks",   d, woe_n[d],                  e.we ? ac + 1 : 0);
                        chk("wdata_oe_hold",   d, bus_wdata_oe[d],           e.we);
                        chk("bus_active_clks", d, act_n[d],                  ac + 2);
                        if (e.we) chk("bus_wdata", d, bus_wdata[d], e.wdata);
                        if (e.gap >= 0) chk("b2b_gap", d, base[d] - last_rsp[d], e.gap);
                        $display("txn dut%0d we=%0d addr=%05h rdata=%02h latency=%0d strobe_clks=%0d",
                                 d, e.we, bus_addr[d], rsp_rdata[d], cyc - base[d],
                                 e.we ? we_n[d] : oe_n[d]);
                    end
                    busy[d]     = 0;
                    last_rsp[d] = cyc;
                end
            end
            if (reset === 1'b0 && cmd_valid[d] === 1'b1 && cmd_ready[d] === 1'b1) begin
                busy[d]        = 1;
                base[d]        = cyc;
                trk_addr[d]    = cmd_addr[d];
                oe_n[d]        = 0;
                we_n[d]        = 0;
                woe_n[d]       = 0;
                act_n[d]       = 0;
                strobe_last[d] = 0;
                addr_bad[d]    = 0;
            end
        end
        prev_reset = (reset === 1'b1);
        if (done_req && !done_ack) begin
            chk("pending_rsp", 0, q0.size(), 0);
            chk("pending_rsp", 1, q1.size(), 0);
            chk("stray_bus",   0, stray[0],  0);
            chk("stray_bus",   1, stray[1],  0);
            done_ack = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic we, input logic [16:0] addr, input logic [7:0] wd,
                                input logic [7:0] rd, input int lat, input int gap);
        exp_t e;
        e.we = we; e.addr = addr; e.wdata = wd; e.rdata = rd; e.latency = lat; e.gap = gap;
        return e;
    endfunction

    // Presents a command and returns #1 after the accepting edge (cycle 1).
    task automatic issue(input int d, input logic we, input logic [16:0] addr,
                         input logic [7:0] wd, input bit keep);
        int n;
        n = 0;
        cmd_valid[d] = 1'b1;
        cmd_we[d]    = we;
        cmd_addr[d]  = addr;
        cmd_wdata[d] = wd;
        @(negedge clk);
        while (cmd_ready[d] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        if (!keep) cmd_valid[d] = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0; cmd_we[d] = 1'b0; cmd_addr[d] = '0; cmd_wdata[d] = '0;
            slot_grant[d] = 1'b1; bus_rdata[d] = '0;
        end
        wait_clks(3);
        reset = 1'b0;
        wait_clks(2);

        // Read 0x8000, grant always high.
        bus_rdata[0] = 8'hA5;
        q0.push_back(mk(1'b0, 17'h08000, 8'h00, 8'hA5, 6, -1));
        issue(0, 1'b0, 17'h08000, 8'h00, 1'b0);
        wait_clks(8);

        // Write 0xE810 <- 0x3C, grant low for 10 clocks after accept.
        slot_grant[0] = 1'b0;
        q0.push_back(mk(1'b1, 17'h0E810, 8'h3C, 8'hA5, 16, -1));
        issue(0, 1'b1, 17'h0E810, 8'h3C, 1'b0);
        wait_clks(10);
        slot_grant[0] = 1'b1;
        wait_clks(8);

        // Back-to-back with cmd_valid held high.
        bus_rdata[0] = 8'h77;
        q0.push_back(mk(1'b0, 17'h00123, 8'h00, 8'h77, 6, -1));
        q0.push_back(mk(1'b1, 17'h00200, 8'h99, 8'h77, 6, 1));
        issue(0, 1'b0, 17'h00123, 8'h00, 1'b1);
        issue(0, 1'b1, 17'h00200, 8'h99, 1'b0);
        wait_clks(8);

        // Grant dropped during STROBE.
        bus_rdata[0] = 8'hC3;
        q0.push_back(mk(1'b0, 17'h1F0F0, 8'h00, 8'hC3, 6, -1));
        issue(0, 1'b0, 17'h1F0F0, 8'h00, 1'b0);
        wait_clks(2);
        slot_grant[0] = 1'b0;
        wait_clks(6);
        slot_grant[0] = 1'b1;

        // Reset during the 2nd STROBE clock of a write: no response expected.
        issue(0, 1'b1, 17'h00055, 8'h11, 1'b0);
        wait_clks(3);
        reset = 1'b1;
        wait_clks(2);
        reset = 1'b0;
        wait_clks(3);

        // After reset: write sees rsp_rdata cleared, then a fresh read.
        bus_rdata[0] = 8'h4B;
        q0.push_back(mk(1'b1, 17'h00020, 8'h22, 8'h00, 6, -1));
        issue(0, 1'b1, 17'h00020, 8'h22, 1'b0);
        wait_clks(8);
        q0.push_back(mk(1'b0, 17'h00010, 8'h00, 8'h4B, 6, -1));
        issue(0, 1'b0, 17'h00010, 8'h00, 1'b0);
        wait_clks(8);

        // Single-clock strobe instance: top address and a write.
        bus_rdata[1] = 8'h5A;
        q1.push_back(mk(1'b0, 17'h1FFFF, 8'h00, 8'h5A, 4, -1));
        issue(1, 1'b0, 17'h1FFFF, 8'h00, 1'b0);
        wait_clks(6);
        q1.push_back(mk(1'b1, 17'h10001, 8'hEE, 8'h5A, 4, -1));
        issue(1, 1'b1, 17'h10001, 8'hEE, 1'b0);
        wait_clks(6);

        done_req = 1'b1;
        n = 0;
        while (!done_ack && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (!done_ack) begin
            $display("FAIL final_check: got no completion expected completion");
            $fatal(1, "monitor did not complete");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
